ddc_rate_ctrl: RTL

DDC_RATE_CTRL -- requirements
Module: ddc_rate_ctrl

---
 rtl/ddc_rate_ctrl_pkg.sv | 38 +++
 rtl/ddc_decim_decode.sv | 44 ++++
 rtl/ddc_rate_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/ddc_rate_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// ddc_rate_ctrl_pkg
// Definitions shared between the DDC rate controller and the DDC chain it
// programs: controller state encoding, settings-bus register offsets, field
// widths, and helpers that pack the settings-bus data words.
// -----------------------------------------------------------------------------
package ddc_rate_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DECODE   = 3'd1,
    ST_QUIESCE  = 3'd2,
    ST_WR_SCALE = 3'd3,
    ST_WR_RATE  = 3'd4,
    ST_SETTLE   = 3'd5
  } state_t;

  // Register offsets relative to the chain's settings-bus base address.
  localparam int SCALE_OFS = 1;
  localparam int RATE_OFS  = 2;

  localparam int DECIM_W = 11;
  localparam int SCALE_W = 18;
  localparam int CIC_W   = 8;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;

  function automatic logic [DATA_W-1:0] scale_word(input logic [SCALE_W-1:0] scale);
    return {14'b0, scale};
  endfunction

  // Rate register layout: [9] hb1 enable, [8] hb2 enable, [7:0] CIC decimation.
  function automatic logic [DATA_W-1:0] rate_word(input logic hb1, input logic hb2,
                                                  input logic [CIC_W-1:0] cic);
    return {22'b0, hb1, hb2, cic};
  endfunction

endpackage

// File: rtl/ddc_decim_decode.sv
// -----------------------------------------------------------------------------
// ddc_decim_decode
// Purely combinational split of a total decimation into the CIC rate and the
// two half-band enables. Preference order: both half-bands (decim/4), then one
// half-band (decim/2), then CIC only. Only bit tests and fixed shifts are used.
// Ports:
//   decim  in  11  requested total decimation
//   cic    out  8  CIC decimation
//   hb1    out  1  first half-band enable
//   hb2    out  1  second half-band enable
//   err    out  1  decimation not representable
// -----------------------------------------------------------------------------
module ddc_decim_decode
  import ddc_rate_ctrl_pkg::*;
(
  input  logic [DECIM_W-1:0] decim,
  output logic [CIC_W-1:0]   cic,
  output logic               hb1,
  output logic               hb2,
  output logic               err
);

  always_comb begin
    cic = '0;
    hb1 = 1'b0;
    hb2 = 1'b0;
    err = 1'b0;
    // decim/4 in 1..255: low two bits clear, bit 10 clear, bits [9:2] non-zero.
    if (decim[1:0] == 2'b00 && !decim[10] && decim[9:2] != '0) begin
      hb1 = 1'b1;
      hb2 = 1'b1;
      cic = decim[9:2];
    // decim/2 in 1..255: bit 0 clear, bits [10:9] clear, bits [8:1] non-zero.
    end else if (!decim[0] && decim[10:9] == 2'b00 && decim[8:1] != '0) begin
      hb1 = 1'b1;
      cic = decim[8:1];
    end else if (decim[10:8] == 3'b000 && decim[7:0] != '0) begin
      cic = decim[7:0];
    end else begin
      err = 1'b1;
    end
  end

endmodule

// File: rtl/ddc_rate_ctrl.sv
// -----------------------------------------------------------------------------
// ddc_rate_ctrl
// Reprograms the decimation rate and output scale of a DDC chain. A request is
// captured in IDLE, decoded, and (if the chain was running) the chain is held
// stopped for FLUSH_CYCLES before two settings-bus writes: scale, then rate.
// Two settle cycles follow before run is handed back to the RX control.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   cfg_valid/cfg_ready    request handshake (ready only in IDLE)
//   cfg_decim [10:0]       requested total decimation
//   cfg_scale [17:0]       output scale factor
//   run_in / run_out       run request in, gated registered run out
//   set_stb/addr/data      settings-bus write (addr/data hold between strobes)
//   cfg_err                one-cycle pulse when a request cannot be decoded
//   cur_cic/hb1/hb2        last programmed rate
//   busy                   state is not IDLE
// -----------------------------------------------------------------------------
module ddc_rate_ctrl
  import ddc_rate_ctrl_pkg::*;
#(
  parameter int BASE         = 0,
  parameter int FLUSH_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [DECIM_W-1:0] cfg_decim,
  input  logic [SCALE_W-1:0] cfg_scale,
  input  logic               run_in,
  output logic               run_out,
  output logic               set_stb,
  output logic [ADDR_W-1:0]  set_addr,
  output logic [DATA_W-1:0]  set_data,
  output logic               cfg_err,
  output logic [CIC_W-1:0]   cur_cic,
  output logic               cur_hb1,
  output logic               cur_hb2,
  output logic               busy
);

  localparam logic [ADDR_W-1:0] SCALE_ADDR = ADDR_W'(BASE + SCALE_OFS);
  localparam logic [ADDR_W-1:0] RATE_ADDR  = ADDR_W'(BASE + RATE_OFS);
  localparam logic [9:0]        FLUSH_LAST = 10'(FLUSH_CYCLES - 1);

  state_t state, next_state;

  logic [DECIM_W-1:0] decim_q;
  logic [SCALE_W-1:0] scale_q;
  logic               run_q;
  logic [9:0]         flush_cnt;
  logic               settle_q;

  logic [CIC_W-1:0]   dec_cic;
  logic               dec_hb1;
  logic               dec_hb2;
  logic               dec_err;

  // The decoder sees only the captured request, so input changes after
  // acceptance cannot disturb a sequence in flight.
  ddc_decim_decode u_decode (
    .decim (decim_q),
    .cic   (dec_cic),
    .hb1   (dec_hb1),
    .hb2   (dec_hb2),
    .err   (dec_err)
  );

  assign cfg_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

  always_comb begin
    next_state = state;
    cfg_err    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cfg_valid) next_state = ST_DECODE;
      end
      ST_DECODE: begin
        if (dec_err) begin
          next_state = ST_IDLE;
          cfg_err    = 1'b1;
        end else if (run_q) begin
          next_state = ST_QUIESCE;
        end else begin
          next_state = ST_WR_SCALE;
        end
      end
      ST_QUIESCE: begin
        if (flush_cnt == FLUSH_LAST) next_state = ST_WR_SCALE;
      end
      ST_WR_SCALE: next_state = ST_WR_RATE;
      ST_WR_RATE:  next_state = ST_SETTLE;
      ST_SETTLE: begin
        if (settle_q) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Request capture: loaded on acceptance only, held for the whole sequence.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && cfg_valid) begin
      decim_q <= cfg_decim;
      scale_q <= cfg_scale;
      run_q   <= run_in;
    end
  end

  // Control and bus outputs: registered from next_state so the strobe and
  // readback are visible during the WR_* state itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      flush_cnt <= '0;
      settle_q  <= 1'b0;
      set_stb   <= 1'b0;
      set_addr  <= '0;
      set_data  <= '0;
      run_out   <= 1'b0;
      cur_cic   <= '0;
      cur_hb1   <= 1'b0;
      cur_hb2   <= 1'b0;
    end else begin
      state     <= next_state;
      flush_cnt <= (state == ST_QUIESCE && next_state == ST_QUIESCE) ? flush_cnt + 10'd1 : '0;
      settle_q  <= (state == ST_SETTLE) && !settle_q;
      run_out   <= run_in && (next_state == ST_IDLE);
      set_stb   <= 1'b0;
      case (next_state)
        ST_WR_SCALE: begin
          set_stb  <= 1'b1;
          set_addr <= SCALE_ADDR;
          set_data <= scale_word(scale_q);
        end
        ST_WR_RATE: begin
          set_stb  <= 1'b1;
          set_addr <= RATE_ADDR;
          set_data <= rate_word(dec_hb1, dec_hb2, dec_cic);
          cur_cic  <= dec_cic;
          cur_hb1  <= dec_hb1;
          cur_hb2  <= dec_hb2;
        end
        default: ;
      endcase
    end
  end

endmodule
